com_reg_arbiter: RTL and testbench
==================================

# com_reg_arbiter

Two-requester round-robin arbiter and AXI4-Lite master sequencer that shares the COM_IP register slave (four 32-bit registers at byte offsets 0x0, 0x4, 0x8, 0xC) between two on-chip clients, e.g. the PWM step scheduler and the host-command bridge. It accepts one simple request per client, issues exactly one single-beat AXI4-Lite write or read, and returns the read data and response status with a one-cycle acknowledge. It sits between the clients and the slave's S00_AXI port on the same ACLK domain.

## Interface
- C_ADDR_WIDTH, 4, AXI address width in bits; client addresses are byte addresses and must be word-aligned.
- C_DATA_WIDTH, 32, data width; only 32 is supported.
- ACLK  in  1  sole clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- req  in  2  per-client request; bit i is client i.
- we  in  2  per-client direction: 1 = write, 0 = read.
- addr  in  2*C_ADDR_WIDTH  per-client byte address; client i uses slice [i*C_ADDR_WIDTH +: C_ADDR_WIDTH].
- wdata  in  2*C_DATA_WIDTH  per-client write data, sliced the same way.
- ack  out  2  one-cycle completion pulse to the owning client.
- rdata  out  C_DATA_WIDTH  read data; valid only while ack is high; 0 after writes.
- err  out  1  high with ack when the response was SLVERR or DECERR (resp[1] = 1).
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master channels; awprot = arprot = 3'b000, wstrb = 4'hF.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: if any req bit is high, grant using a round-robin pointer `last`. Client 0 wins when last = 1 or only req[0] is high; client 1 wins when last = 0 or only req[1] is high. On grant, latch we, addr and wdata of the winner; update last to the winner; go to WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid are asserted together. Each drops independently after its own handshake (valid & ready), in any order or in the same cycle. When both handshakes are done, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, capture bresp and go to DONE.
- RD_REQ: arvalid = 1 until arready, then go to RD_RESP.
- RD_RESP: rready = 1. On rvalid, capture rdata and rresp and go to DONE.
- DONE: ack[owner] = 1 for exactly one cycle, with rdata and err valid. Then go to IDLE. req is not sampled in DONE, so a client may drop req in its ack cycle.
- A req still high in IDLE after its ack is treated as a new request.
- Clients must hold req, we, addr and wdata stable until ack. Fields are sampled only at grant.
- Address handling: the latched addr is driven unchanged. Bits [1:0] must be 0; the block does not check them.
- The arbiter never holds two transactions outstanding.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, last = 1, all valid and ready outputs = 0, ack = 0, err = 0, rdata = 0, awaddr/araddr/wdata = 0.
- All outputs are registered; none depends combinationally on AXI inputs or req.
- Minimum write, with awready/wready high and bvalid returned the cycle after:
  - grant at edge 0;
  - AW/W valid cycle 1;
  - bready/bvalid handshake cycle 2;
  - ack cycle 3;
  - IDLE cycle 4.
  - Back-to-back throughput: one transaction per 4 cycles.
- Minimum read: the same 4-cycle profile with AR/R.
- Valid signals never drop before their handshake.
- ARESETN asserted mid-transaction aborts immediately: valids drop, state goes to IDLE, and no ack is issued. The slave is reset by the same ARESETN.
- Simultaneous req[0] and req[1] in IDLE: exactly one grant, per the pointer. The loser is served next, before any re-request from the winner.

## Test plan
- Client 0 writes 0x00000001, 0x00000002, 0x00000003, 0x00000004 to 0x0/0x4/0x8/0xC, then reads them back -> each ack has err = 0 and rdata = 0x1..0x4 in order.
- Both reqs held high continuously from reset, client 0 reading 0x4 and client 1 reading 0x8 -> grants alternate 0,1,0,1; ack spacing is 4 cycles with an immediate-ready slave.
- Slave delays wready 5 cycles after awready -> awvalid drops after its handshake, wvalid holds 5 cycles, a single B handshake follows, ack once.
- Slave returns bresp = 2'b10 on a write of 0xDEADBEEF to 0xC -> ack with err = 1, rdata = 0.
- ARESETN pulsed low while in RD_RESP for client 1 -> all outputs return to reset values asynchronously; no ack; the next request is granted to client 0 first.
- Client 1 drops req in its ack cycle while client 0 requests -> client 0 is granted in the following IDLE cycle; no spurious second client 1 transaction.

Source files
------------

// File: rtl/com_reg_arbiter_if.sv
// AXI4-Lite master/slave channel bundle between com_reg_arbiter and the COM_IP register slave.
interface com_reg_arbiter_if #(
   parameter int unsigned C_ADDR_WIDTH = 4,
   parameter int unsigned C_DATA_WIDTH = 32
);
   logic [C_ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]                awprot;
   logic                      awvalid;
   logic                      awready;
   logic [C_DATA_WIDTH-1:0]   wdata;
   logic [C_DATA_WIDTH/8-1:0] wstrb;
   logic                      wvalid;
   logic                      wready;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;
   logic [C_ADDR_WIDTH-1:0]   araddr;
   logic [2:0]                arprot;
   logic                      arvalid;
   logic                      arready;
   logic [C_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                rresp;
   logic                      rvalid;
   logic                      rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
             rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
             rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/com_reg_arbiter.sv
// Two-client round-robin arbiter issuing one single-beat AXI4-Lite access at a time.
module com_reg_arbiter #(
   parameter int unsigned C_ADDR_WIDTH = 4,
   parameter int unsigned C_DATA_WIDTH = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [1:0]                req,
   input  logic [1:0]                we,
   input  logic [2*C_ADDR_WIDTH-1:0] addr,
   input  logic [2*C_DATA_WIDTH-1:0] wdata,
   output logic [1:0]                ack,
   output logic [C_DATA_WIDTH-1:0]   rdata,
   output logic                      err,
   com_reg_arbiter_if.master         m_axi
);

   typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone} state_e;

   state_e                    state_q, state_d;
   logic                      last_q, last_d;
   logic                      owner_q, owner_d;
   logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      grant;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      // A lone requester always wins; on contention the pointer favours the other client.
      if (req == 2'b01)      grant = 1'b0;
      else if (req == 2'b10) grant = 1'b1;
      else                   grant = ~last_q;

      case (state_q)
         StIdle: begin
            if (|req) begin
               owner_d = grant;
               last_d  = grant;
               addr_d  = grant ? addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH] : addr[C_ADDR_WIDTH-1:0];
               wdata_d = grant ? wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH] : wdata[C_DATA_WIDTH-1:0];
               if (we[grant]) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWrReq;
               end else begin
                  state_d   = StRdReq;
               end
            end
         end
         StWrReq: begin
            // AW and W complete independently; leave once both have handshaken.
            awvalid_d = awvalid_q & ~m_axi.awready;
            wvalid_d  = wvalid_q & ~m_axi.wready;
            if (!awvalid_d && !wvalid_d) state_d = StWrResp;
         end
         StWrResp: begin
            if (m_axi.bvalid) begin
               err_d   = m_axi.bresp[1];
               rdata_d = '0;
               state_d = StDone;
            end
         end
         StRdReq: begin
            if (m_axi.arready) state_d = StRdResp;
         end
         StRdResp: begin
            if (m_axi.rvalid) begin
               err_d   = m_axi.rresp[1];
               rdata_d = m_axi.rdata;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Outputs decode only registered state, never the AXI inputs or req.
   assign m_axi.awaddr  = addr_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = '1;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = (state_q == StWrResp);
   assign m_axi.arvalid = (state_q == StRdReq);
   assign m_axi.rready  = (state_q == StRdResp);

   assign ack   = (state_q == StDone) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign err   = (state_q == StDone) & err_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_com_reg_arbiter.sv
// Scoreboard bench for com_reg_arbiter with a behavioural register slave and memory model.
module tb_com_reg_arbiter;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [7:0]  addr;
   logic [63:0] wdata;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic        err;

   logic        c_req [2];
   logic        c_we [2];
   logic [3:0]  c_addr [2];
   logic [31:0] c_wdata [2];

   assign req   = {c_req[1], c_req[0]};
   assign we    = {c_we[1], c_we[0]};
   assign addr  = {c_addr[1], c_addr[0]};
   assign wdata = {c_wdata[1], c_wdata[0]};

   com_reg_arbiter_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) m_axi ();

   com_reg_arbiter #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .ack     (ack),
      .rdata   (rdata),
      .err     (err),
      .m_axi   (m_axi)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic [31:0] smem [4];
   logic        aw_got, w_got, ar_got;
   logic [3:0]  s_awaddr, s_araddr;
   logic [31:0] s_wdata;
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

   // Writes whose data has top nibble 0xD are refused with SLVERR.
   assign m_axi.awready = m_axi.awvalid && !aw_got && (aw_cnt >= aw_dly);
   assign m_axi.wready  = m_axi.wvalid && !w_got && (w_cnt >= w_dly);
   assign m_axi.bvalid  = aw_got && w_got && (b_cnt >= b_dly);
   assign m_axi.bresp   = (s_wdata[31:28] == 4'hD) ? 2'b10 : 2'b00;
   assign m_axi.arready = m_axi.arvalid && !ar_got && (ar_cnt >= ar_dly);
   assign m_axi.rvalid  = ar_got && (r_cnt >= r_dly);
   assign m_axi.rdata   = smem[s_araddr[3:2]];
   assign m_axi.rresp   = 2'b00;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
         s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         for (int i = 0; i < 4; i++) smem[i] <= '0;
      end else begin
         if (m_axi.awvalid && m_axi.awready) begin
            aw_got <= 1'b1; s_awaddr <= m_axi.awaddr; aw_cnt <= 0;
         end else if (m_axi.awvalid) aw_cnt <= aw_cnt + 1;
         if (m_axi.wvalid && m_axi.wready) begin
            w_got <= 1'b1; s_wdata <= m_axi.wdata; w_cnt <= 0;
         end else if (m_axi.wvalid) w_cnt <= w_cnt + 1;
         if (m_axi.bvalid && m_axi.bready) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            if (m_axi.bresp == 2'b00) smem[s_awaddr[3:2]] <= s_wdata;
         end else if (aw_got && w_got) b_cnt <= b_cnt + 1;
         if (m_axi.arvalid && m_axi.arready) begin
            ar_got <= 1'b1; s_araddr <= m_axi.araddr; ar_cnt <= 0;
         end else if (m_axi.arvalid) ar_cnt <= ar_cnt + 1;
         if (m_axi.rvalid && m_axi.rready) begin
            ar_got <= 1'b0; r_cnt <= 0;
         end else if (ar_got) r_cnt <= r_cnt + 1;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [31:0] model_mem [4];
   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   log_owner[$];
   int   log_cyc[$];
   int   wonly_cnt = 0;
   int   b_hs = 0;
   logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
   exp_t mon_e;

   always @(negedge ACLK) begin
      if (ARESETN) begin
         if (ack == 2'b11) chk("ack_onehot", {30'd0, ack}, 32'd1);
         for (int c = 0; c < 2; c++) begin
            if (ack[c]) begin
               log_owner.push_back(c);
               log_cyc.push_back(cyc);
               if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_ack client %0d: got ack, expected none", c);
               end else begin
                  if (c == 0) mon_e = exp_q0.pop_front();
                  else        mon_e = exp_q1.pop_front();
                  chk($sformatf("c%0d_rdata", c), rdata, mon_e.rdata);
                  chk($sformatf("c%0d_err", c), {31'd0, err}, {31'd0, mon_e.err});
               end
            end
         end
         if (aw_pend) chk("awvalid_held", {31'd0, m_axi.awvalid}, 32'd1);
         if (w_pend)  chk("wvalid_held", {31'd0, m_axi.wvalid}, 32'd1);
         if (ar_pend) chk("arvalid_held", {31'd0, m_axi.arvalid}, 32'd1);
         if (m_axi.awvalid && m_axi.awready) chk("awprot", {29'd0, m_axi.awprot}, 32'd0);
         if (m_axi.wvalid && m_axi.wready)   chk("wstrb", {28'd0, m_axi.wstrb}, 32'hF);
         if (m_axi.arvalid && m_axi.arready) chk("arprot", {29'd0, m_axi.arprot}, 32'd0);
         if (m_axi.wvalid && !m_axi.awvalid) wonly_cnt++;
         if (m_axi.bvalid && m_axi.bready) b_hs++;
      end
      aw_pend = ARESETN && m_axi.awvalid && !m_axi.awready;
      w_pend  = ARESETN && m_axi.wvalid && !m_axi.wready;
      ar_pend = ARESETN && m_axi.arvalid && !m_axi.arready;
   end

   // Issue one request, queue its expected completion, wait (bounded) for ack.
   task automatic do_txn(input int c, input bit w, input logic [3:0] a, input logic [31:0] d,
                         input bit hold);
      exp_t e;
      bit   got;
      if (w) begin
         e.rdata = '0;
         e.err   = (d[31:28] == 4'hD);
         if (!e.err) model_mem[a[3:2]] = d;
      end else begin
         e.rdata = model_mem[a[3:2]];
         e.err   = 1'b0;
      end
      if (c == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      c_we[c] = w; c_addr[c] = a; c_wdata[c] = d; c_req[c] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge ACLK);
         got = ack[c];
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL ack_timeout client %0d: got no ack, expected ack within 300 cycles", c);
      end
      if (!hold) c_req[c] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected end before 500000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, w0, b0;
      for (int i = 0; i < 2; i++) begin
         c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0;
      end
      for (int i = 0; i < 4; i++) model_mem[i] = '0;

      // Reset values
      #1;
      chk("rst_valids", {27'd0, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid,
                         m_axi.rready}, 32'd0);
      chk("rst_ack", {30'd0, ack}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_addr", {24'd0, m_axi.awaddr, m_axi.araddr}, 32'd0);
      chk("rst_wdata", m_axi.wdata, 32'd0);

      // Both clients reading continuously from reset: strict alternation every 4 cycles
      c_we[0] = 1'b0; c_addr[0] = 4'h4; c_req[0] = 1'b1;
      c_we[1] = 1'b0; c_addr[1] = 4'h8; c_req[1] = 1'b1;
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      s = log_owner.size();
      fork
         for (int k = 0; k < 4; k++) do_txn(0, 1'b0, 4'h4, 32'd0, k < 3);
         for (int k = 0; k < 4; k++) do_txn(1, 1'b0, 4'h8, 32'd0, k < 3);
      join
      repeat (2) @(negedge ACLK);
      chk("alt_count", log_owner.size() - s, 32'd8);
      for (int i = s; i < log_owner.size(); i++) begin
         chk($sformatf("alt_owner_%0d", i - s), log_owner[i], (i - s) % 2);
         if (i > s) chk($sformatf("alt_spacing_%0d", i - s), log_cyc[i] - log_cyc[i-1], 32'd4);
      end

      // Client 0 writes then reads back all four registers
      for (int k = 0; k < 4; k++) do_txn(0, 1'b1, 4'(k * 4), 32'(k + 1), 1'b0);
      for (int k = 0; k < 4; k++) do_txn(0, 1'b0, 4'(k * 4), 32'd0, 1'b0);

      // W channel held off 5 cycles after AW completes
      aw_dly = 0; w_dly = 5;
      w0 = wonly_cnt; b0 = b_hs;
      do_txn(0, 1'b1, 4'h0, 32'h0000_0055, 1'b0);
      chk("wdelay_wonly_cycles", wonly_cnt - w0, 32'd5);
      chk("wdelay_b_handshakes", b_hs - b0, 32'd1);
      w_dly = 0;

      // Slave error on write; register must keep its old value
      do_txn(0, 1'b1, 4'hC, 32'hDEAD_BEEF, 1'b0);
      do_txn(0, 1'b0, 4'hC, 32'd0, 1'b0);

      // Reset while client 1 waits for read data
      r_dly = 20;
      c_we[1] = 1'b0; c_addr[1] = 4'h8; c_req[1] = 1'b1;
      for (int i = 0; i < 50 && !m_axi.rready; i++) @(negedge ACLK);
      chk("abort_reached_rresp", {31'd0, m_axi.rready}, 32'd1);
      #2 ARESETN = 1'b0;
      #1;
      chk("abort_valids", {27'd0, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid,
                           m_axi.rready}, 32'd0);
      chk("abort_ack", {30'd0, ack}, 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      chk("abort_addr", {28'd0, m_axi.araddr}, 32'd0);
      c_req[1] = 1'b0;
      r_dly = 0;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      s = log_owner.size();
      fork
         do_txn(0, 1'b0, 4'h0, 32'd0, 1'b0);
         do_txn(1, 1'b0, 4'h8, 32'd0, 1'b0);
      join
      chk("abort_first_grant", log_owner[s], 32'd0);

      // Client 1 drops req in its ack cycle while client 0 is waiting
      repeat (3) @(negedge ACLK);
      s = log_owner.size();
      fork
         do_txn(1, 1'b1, 4'h8, 32'h1234_5678, 1'b0);
         begin
            repeat (2) @(negedge ACLK);
            do_txn(0, 1'b1, 4'h4, 32'h0BAD_F00D, 1'b0);
         end
      join
      repeat (6) @(negedge ACLK);
      chk("drop_ack_count", log_owner.size() - s, 32'd2);
      chk("drop_owner_first", log_owner[s], 32'd1);
      chk("drop_owner_second", log_owner[s+1], 32'd0);
      chk("drop_next_grant", log_cyc[s+1] - log_cyc[s], 32'd4);

      // Random concurrent traffic; each client owns two registers
      fork
         for (int k = 0; k < 30; k++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge ACLK);
            do_txn(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 1) * 4), $urandom, 1'b0);
         end
         for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge ACLK);
            do_txn(1, 1'($urandom_range(0, 1)), 4'(8 + $urandom_range(0, 1) * 4), $urandom,
                   1'b0);
         end
      join
      repeat (10) @(negedge ACLK);
      chk("scoreboard_drained", exp_q0.size() + exp_q1.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
